transmisor_multicarril: RTL and testbench
=========================================

# transmisor_multicarril

Parametrised multi-lane successor to the single-lane PCIE-interface transmitter. It accepts 8/16/32-bit words through a valid/ready handshake and stripes their bytes round-robin across `LANES` lanes. Each lane has its own byte FIFO and an 8-bit serializer. A lane with no data emits the idle K symbol, so every lane always carries symbol-aligned traffic. It sits between the packet/data source and the per-lane differential emitters.

## Interface
Parameters:
- `LANES`, 2: number of serial lanes; legal values 1, 2, 4.
- `FIFO_DEPTH`, 8: bytes per lane FIFO; power of two, ≥4.
- `IDLE_SYM`, 8'hBC: symbol sent, with K=1, when a lane FIFO is empty.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `enb` in 1: global enable; when low, all state freezes.
- `dataIn` in 32: byte i = `dataIn[8i+7:8i]`.
- `kIn` in 4: per-byte K flag, aligned with `dataIn` bytes.
- `dataS` in 2: width select. 00 = 1 byte, 01 = 2 bytes, 10 = 4 bytes, 11 = 4 bytes.
- `validIn` in 1: word present.
- `readyOut` out 1: block can accept a word this cycle.
- `serialOut` out LANES: serial bit per lane, LSB first.
- `kOut` out LANES: K flag of the symbol currently on the lane, held for all 8 bits.
- `symStart` out LANES: high during bit 0 of each symbol.

## Operation
- Transfer occurs on a rising edge with `validIn & readyOut & enb`.
- N = 1, 2 or 4 bytes per `dataS`. Byte i, with its `kIn[i]`, is pushed to lane `(lanePtr+i) mod LANES`. `lanePtr` then advances by N mod LANES.
- `readyOut` = `enb & ~rst`, and every lane FIFO has ≥ ceil(4/LANES) free entries. This is independent of `dataS`, so no lane can overflow.
- A common bit counter `bitCnt` (0..7) is shared by all lanes, so lanes stay symbol-aligned.
- When `bitCnt` wraps 7→0, each lane loads its next symbol:
  - If its FIFO is non-empty: the head byte and its K flag, and the FIFO is popped.
  - Otherwise: `IDLE_SYM` with K=1.
- `serialOut[l]` = `shift[l][bitCnt]`.
- Push and pop on the same FIFO in the same cycle are both honoured; the count is unchanged.
- No internal handshake beyond `readyOut` is needed.
- `validIn` without `readyOut` is ignored; no byte is lost or duplicated.

## Timing
- Reset: `serialOut`=0, `kOut`=0, `symStart`=0, `readyOut`=0. FIFOs are emptied, `lanePtr`=0, `bitCnt`=7.
- On the first enabled edge after reset, every lane loads `IDLE_SYM`. `symStart`=1 with `bitCnt`=0.
- Per-lane symbol rate is one symbol per 8 enabled cycles.
- Latency: a byte accepted at edge t enters the FIFO at t. It is loaded at the first symbol boundary after t, so its first bit appears 1–8 cycles later when the FIFO was empty.
- `enb`=0: `bitCnt`, shifters, FIFOs and `lanePtr` hold; outputs hold their last values; `readyOut`=0.
- `rst` mid-symbol or with FIFOs full: all queued bytes are discarded, and output restarts with idle on the next enabled edge.

## Configuration
- `TRANSMISOR_SCRAMBLER_EN` defined:
  - Each lane has an LFSR, polynomial x^16+x^5+x^4+x^3+1, seeded 16'hFFFF on `rst`.
  - The LFSR advances 8 steps per symbol load.
  - Data symbols (K=0) are XORed with the 8 LFSR output bits before serialization.
  - K symbols are sent unscrambled.
  - A loaded symbol equal to `IDLE_SYM` with K=1 reseeds that lane's LFSR to 16'hFFFF.
- Undefined: no LFSR logic, and bytes are sent verbatim.

## Structure
- The shared package holds:
  - the `dataS` encodings (W8=2'b00, W16=2'b01, W32=2'b10);
  - the default `IDLE_SYM`;
  - the LFSR seed and tap constants;
  - the ceil(4/LANES) free-space function.
- One sub-module, `carril_serializador`: the per-lane FIFO plus shifter (and LFSR when enabled), instantiated LANES times via generate.
- The top level holds `bitCnt`, `lanePtr`, striping and `readyOut`.

## Test plan
All scenarios use LANES=2 and scrambler undefined unless stated.
- Reset, then enable with no `validIn` → both lanes emit 8'hBC with `kOut`=1 continuously, and `symStart` every 8 cycles.
- `dataS`=10, `dataIn`=32'h0123456f, `kIn`=0 → lane0 sends 6f then 23; lane1 sends 45 then 01; idle afterwards.
- Three single-byte words 8'hAA, 8'hBB, 8'hCC with `dataS`=00 → lane0 gets AA, CC; lane1 gets BB (checks `lanePtr` rotation).
- `validIn` held high with 32-bit words → `readyOut` drops once a FIFO has <2 free entries. The serial stream matches the accepted words byte-for-byte, with no loss or duplication.
- `enb` low for 5 cycles mid-symbol → outputs are frozen and the resumed bit sequence is unbroken. Pulsing `rst` with full FIFOs → idle symbols only.
- Scrambler defined, LANES=1, byte 8'h00 after reset → output equals the first 8 LFSR bits from seed FFFF (reference model). A K=1 byte 8'h1C is sent unscrambled.

Source files
------------

// File: rtl/transmisor_multicarril_pkg.sv
// Shared definitions for the multi-lane transmitter: width encodings, idle symbol,
// scrambler constants and the per-lane free-space rule.
package transmisor_multicarril_pkg;

    typedef enum logic [1:0] {
        W8   = 2'b00,
        W16  = 2'b01,
        W32  = 2'b10,
        W32B = 2'b11
    } width_e;

    typedef struct packed {
        logic       k;
        logic [7:0] data;
    } sym_t;

    localparam logic [7:0]  IDLE_SYM_DEF = 8'hBC;
    localparam logic [15:0] LFSR_SEED    = 16'hFFFF;
    // x^16 + x^5 + x^4 + x^3 + 1 : feedback from bits 15, 4, 3, 2
    localparam logic [15:0] LFSR_TAPS    = 16'h801C;

    function automatic int free_need(int lanes);
        return (4 + lanes - 1) / lanes;
    endfunction

    function automatic logic [2:0] width_bytes(logic [1:0] sel);
        case (width_e'(sel))
            W8:      return 3'd1;
            W16:     return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/transmisor_multicarril_if.sv
// Word-side handshake and per-lane serial outputs of the multi-lane transmitter.
interface transmisor_multicarril_if #(parameter int LANES = 2);
    logic [31:0]      dataIn;
    logic [3:0]       kIn;
    logic [1:0]       dataS;
    logic             validIn;
    logic             readyOut;
    logic [LANES-1:0] serialOut;
    logic [LANES-1:0] kOut;
    logic [LANES-1:0] symStart;

    modport master (output dataIn, kIn, dataS, validIn,
                    input  readyOut, serialOut, kOut, symStart);
    modport slave  (input  dataIn, kIn, dataS, validIn,
                    output readyOut, serialOut, kOut, symStart);
endinterface

// File: rtl/transmisor_multicarril_serializador.sv
// One lane: byte FIFO (up to 4 pushes per cycle) feeding an 8-bit serializer.
// Optional per-lane scrambler under TRANSMISOR_SCRAMBLER_EN.
module carril_serializador
    import transmisor_multicarril_pkg::*;
#(
    parameter int         FIFO_DEPTH = 8,
    parameter logic [7:0] IDLE_SYM   = IDLE_SYM_DEF,
    localparam int        AW         = $clog2(FIFO_DEPTH),
    localparam int        CW         = AW + 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [2:0]     push_cnt,
    input  sym_t [3:0]     push_sym,
    input  logic           load,
    input  logic [2:0]     bit_sel,
    output logic           ser,
    output logic           k_out,
    output logic [CW-1:0]  free
);

    sym_t          mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [7:0]    shift;
    logic          k_q;
    logic          pop;
    sym_t          nxt;
    logic [7:0]    sym_data;

    assign pop = load && (count != '0);
    assign nxt = pop ? mem[rd_ptr] : sym_t'{k: 1'b1, data: IDLE_SYM};

    always_ff @(posedge clk) begin
        for (int j = 0; j < 4; j++)
            if (3'(j) < push_cnt)
                mem[wr_ptr + AW'(j)] <= push_sym[j];
    end

`ifdef TRANSMISOR_SCRAMBLER_EN
    logic [15:0] lfsr, lfsr_adv;
    logic [7:0]  scr;

    // Eight LFSR steps per symbol; scr[j] scrambles serial bit j.
    always_comb begin
        lfsr_adv = lfsr;
        scr      = '0;
        for (int j = 0; j < 8; j++) begin
            scr[j]   = lfsr_adv[15];
            lfsr_adv = {lfsr_adv[14:0], ^(lfsr_adv & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            lfsr <= LFSR_SEED;
        else if (load)
            lfsr <= (nxt == sym_t'{k: 1'b1, data: IDLE_SYM}) ? LFSR_SEED : lfsr_adv;
    end

    assign sym_data = nxt.k ? nxt.data : (nxt.data ^ scr);
`else
    assign sym_data = nxt.data;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            shift  <= '0;
            k_q    <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push_cnt);
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push_cnt) - CW'(pop);
            if (load) begin
                shift <= sym_data;
                k_q   <= nxt.k;
            end
        end
    end

    assign ser   = shift[bit_sel];
    assign k_out = k_q;
    assign free  = CW'(FIFO_DEPTH) - count;

endmodule

// File: rtl/transmisor_multicarril.sv
// Multi-lane transmitter top: byte striping, shared bit counter, readiness.
// Build with TRANSMISOR_SCRAMBLER_EN defined to scramble data symbols per lane.
module transmisor_multicarril
    import transmisor_multicarril_pkg::*;
#(
    parameter int         LANES      = 2,
    parameter int         FIFO_DEPTH = 8,
    parameter logic [7:0] IDLE_SYM   = IDLE_SYM_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enb,
    transmisor_multicarril_if.slave  bus
);

    localparam int         CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int         NEED  = free_need(LANES);
    localparam logic [1:0] LMASK = 2'(LANES - 1);

    logic [2:0]                  bit_cnt;
    logic [1:0]                  lane_ptr;
    logic [2:0]                  nbytes;
    logic                        xfer, load, all_free;
    logic [LANES-1:0][2:0]       push_cnt;
    sym_t [LANES-1:0][3:0]       push_sym;
    logic [LANES-1:0][CW-1:0]    free;
    logic [LANES-1:0]            ser, k_lane;

    // Space for the worst-case word on every lane, whatever dataS says.
    always_comb begin
        all_free = 1'b1;
        for (int l = 0; l < LANES; l++)
            if (free[l] < CW'(NEED))
                all_free = 1'b0;
    end

    assign bus.readyOut = enb & ~rst & all_free;
    assign xfer         = bus.validIn & bus.readyOut;
    assign load         = enb & (bit_cnt == 3'd7);
    assign nbytes       = width_bytes(bus.dataS);

    always_comb begin
        push_cnt = '0;
        push_sym = '0;
        for (int l = 0; l < LANES; l++)
            for (int i = 0; i < 4; i++)
                if (xfer && (3'(i) < nbytes) &&
                    (((lane_ptr + 2'(i)) & LMASK) == 2'(l))) begin
                    push_sym[l][push_cnt[l][1:0]] = sym_t'{k: bus.kIn[i], data: bus.dataIn[8*i +: 8]};
                    push_cnt[l] = push_cnt[l] + 3'd1;
                end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt  <= 3'd7;
            lane_ptr <= '0;
        end else if (enb) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (xfer)
                lane_ptr <= (lane_ptr + nbytes[1:0]) & LMASK;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        carril_serializador #(
            .FIFO_DEPTH (FIFO_DEPTH),
            .IDLE_SYM   (IDLE_SYM)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .push_cnt (push_cnt[l]),
            .push_sym (push_sym[l]),
            .load     (load),
            .bit_sel  (bit_cnt),
            .ser      (ser[l]),
            .k_out    (k_lane[l]),
            .free     (free[l])
        );
    end

    assign bus.serialOut = ser;
    assign bus.kOut      = k_lane;
    assign bus.symStart  = {LANES{bit_cnt == 3'd0}};

endmodule

// File: tb/tb_transmisor_multicarril.sv
// Bench for transmisor_multicarril: directed steps plus random traffic, every cycle
// compared against a queue-based lane model. TRANSMISOR_SCRAMBLER_EN selects LANES=1.
module tb_transmisor_multicarril;

`ifdef TRANSMISOR_SCRAMBLER_EN
    localparam int LANES = 1;
`else
    localparam int LANES = 2;
`endif
    localparam int         DEPTH = 8;
    localparam logic [7:0] IDLE  = 8'hBC;
    localparam int         NEED  = (4 + LANES - 1) / LANES;

    logic clk = 1'b0;
    logic rst, enb;
    always #5 clk = ~clk;

    transmisor_multicarril_if #(.LANES(LANES)) bus ();

    transmisor_multicarril #(.LANES(LANES), .FIFO_DEPTH(DEPTH), .IDLE_SYM(IDLE)) dut (
        .clk (clk),
        .rst (rst),
        .enb (enb),
        .bus (bus)
    );

    // Reference model: per-lane byte queues, the symbol on the wire, bit position.
    logic [8:0]  q [LANES][$];
    logic [7:0]  cur_sym [LANES];
    logic        cur_k   [LANES];
    logic [15:0] lfsr    [LANES];
    int          bpos;
    int          ptr;
    int          total = 0;
    int          npass = 0;
    int          nfail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_lane(input int l);
        logic [8:0] s;
        logic [7:0] bits;
        s = (q[l].size() != 0) ? q[l].pop_front() : {1'b1, IDLE};
`ifdef TRANSMISOR_SCRAMBLER_EN
        if (s == {1'b1, IDLE}) lfsr[l] = 16'hFFFF;
        else begin
            for (int j = 0; j < 8; j++) begin
                bits[j] = lfsr[l][15];
                lfsr[l] = {lfsr[l][14:0], lfsr[l][15] ^ lfsr[l][4] ^ lfsr[l][3] ^ lfsr[l][2]};
            end
            if (!s[8]) s[7:0] = s[7:0] ^ bits;
        end
`else
        bits = '0;
`endif
        cur_sym[l] = s[7:0];
        cur_k[l]   = s[8];
    endtask

    function automatic logic model_ready();
        logic r;
        r = enb && !rst;
        for (int l = 0; l < LANES; l++)
            if (DEPTH - q[l].size() < NEED) r = 1'b0;
        return r;
    endfunction

    task automatic cycle();
        logic       xfer;
        int         n;
        logic [LANES-1:0] es, ek, ess;
        #1;
        chk("readyOut", 32'(bus.readyOut), 32'(model_ready()));
        xfer = bus.validIn && model_ready();
        @(posedge clk);
        if (rst) begin
            for (int l = 0; l < LANES; l++) begin
                q[l].delete();
                cur_sym[l] = '0;
                cur_k[l]   = 1'b0;
                lfsr[l]    = 16'hFFFF;
            end
            bpos = 7;
            ptr  = 0;
        end else if (enb) begin
            if (bpos == 7) begin
                bpos = 0;
                for (int l = 0; l < LANES; l++) load_lane(l);
            end else bpos++;
            if (xfer) begin
                n = (bus.dataS == 2'b00) ? 1 : (bus.dataS == 2'b01) ? 2 : 4;
                for (int i = 0; i < n; i++)
                    q[(ptr + i) % LANES].push_back({bus.kIn[i], bus.dataIn[8*i +: 8]});
                ptr = (ptr + n) % LANES;
            end
        end
        #1;
        for (int l = 0; l < LANES; l++) begin
            es[l]  = cur_sym[l][bpos];
            ek[l]  = cur_k[l];
            ess[l] = (bpos == 0);
        end
        chk("serialOut", 32'(bus.serialOut), 32'(es));
        chk("kOut",      32'(bus.kOut),      32'(ek));
        chk("symStart",  32'(bus.symStart),  32'(ess));
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] k, input logic [1:0] w);
        bus.validIn = v;
        bus.dataIn  = d;
        bus.kIn     = k;
        bus.dataS   = w;
    endtask

    initial begin
        rst = 1'b1;
        enb = 1'b0;
        drive(1'b0, '0, '0, 2'b00);
        bpos = 7;
        ptr  = 0;

        // Reset state, then pure idle traffic
        repeat (3) cycle();
        rst = 1'b0;
        enb = 1'b1;
        repeat (20) cycle();

        // One 32-bit word striped across the lanes
        drive(1'b1, 32'h0123456f, 4'h0, 2'b10);
        cycle();
        bus.validIn = 1'b0;
        repeat (24) cycle();

        // Three single bytes exercise the lane pointer rotation
        drive(1'b1, 32'h000000AA, 4'h0, 2'b00); cycle();
        drive(1'b1, 32'h000000BB, 4'h0, 2'b00); cycle();
        drive(1'b1, 32'h000000CC, 4'h0, 2'b00); cycle();
        bus.validIn = 1'b0;
        repeat (30) cycle();

        // validIn held high with 32-bit words: back-pressure kicks in
        for (int c = 0; c < 60; c++) begin
            drive(1'b1, $urandom, 4'(($urandom_range(0, 7) == 0) ? $urandom : 0), 2'b10);
            cycle();
        end

        // Enable dropped mid-symbol for 5 cycles with data in flight
        repeat (3) cycle();
        enb = 1'b0;
        repeat (5) cycle();
        enb = 1'b1;
        bus.validIn = 1'b0;
        repeat (40) cycle();

        // Random mix of widths, K flags, validIn and enable
        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom), $urandom, 4'($urandom), 2'($urandom));
            enb = ($urandom_range(0, 9) != 0);
            cycle();
        end
        enb = 1'b1;

        // Fill FIFOs, then reset: only idle afterwards
        for (int c = 0; c < 12; c++) begin
            drive(1'b1, $urandom, 4'h0, 2'b10);
            cycle();
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        bus.validIn = 1'b0;
        repeat (30) cycle();

        // Data byte 00 then K byte 1C straight after reset (scrambler case)
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        drive(1'b1, 32'h00000000, 4'h0, 2'b00); cycle();
        drive(1'b1, 32'h0000001C, 4'h1, 2'b00); cycle();
        bus.validIn = 1'b0;
        repeat (32) cycle();

        $display("%0d/%0d checks passed", npass, total);
        $finish;
    end

endmodule
